// File: rtl/dm_pkg.sv
// Shared definitions for the MIPS data memory: access-size encodings,
// the datapath word width and the natural-alignment rule.
package dm_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // A halfword must sit on an even byte, a word on a multiple of four.
    // Size 2'b11 is handled as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            default: bad = (lane != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_load_align.sv
// Read-path alignment: picks the addressed byte or halfword out of the
// stored word and sign- or zero-extends it to the full word width.
module dm_load_align
    import dm_pkg::*;
(
    input  logic [WORD_W-1:0] word,
    input  logic [1:0]        lane,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic              misaligned,
    output logic [WORD_W-1:0] data
);

    // Widen a byte; the signed view makes the sign-extension explicit.
    function automatic logic [WORD_W-1:0] extend_byte(input logic [7:0] b, input logic sx);
        logic signed [7:0]        sb;
        logic signed [WORD_W-1:0] sw;
        sb = b;
        sw = WORD_W'(sb);
        return sx ? sw : {{(WORD_W-8){1'b0}}, b};
    endfunction

    // Widen a halfword the same way.
    function automatic logic [WORD_W-1:0] extend_half(input logic [15:0] h, input logic sx);
        logic signed [15:0]       sh;
        logic signed [WORD_W-1:0] sw;
        sh = h;
        sw = WORD_W'(sh);
        return sx ? sw : {{(WORD_W-16){1'b0}}, h};
    endfunction

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane selection: lane 0 is the least significant byte.
    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    // Final load value; a misaligned access returns zero rather than garbage.
    always_comb begin
        data = '0;
        if (!misaligned) begin
            case (size)
                SZ_BYTE: data = extend_byte(byte_sel, sign_ext);
                SZ_HALF: data = extend_half(half_sel, sign_ext);
                default: data = word;
            endcase
        end
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised data memory for the single-cycle MIPS datapath.
// Combinational read, rising-edge write with byte/halfword/word lane merge,
// and a reset that loads every word with its own index.
module data_memory
    import dm_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       address,
    input  logic [31:0]       write_data,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [31:0]       data,
    output logic              misaligned
);

    logic [WORD_W-1:0]    mem [DEPTH];
    logic [ADDR_BITS-1:0] index;
    logic [1:0]           lane;
    logic [WORD_W-1:0]    rd_word;
    logic [WORD_W-1:0]    wr_word;
    logic [WORD_W-1:0]    wr_mask;
    logic                 unused_addr_hi;

    // Upper address bits are deliberately ignored so accesses wrap.
    assign unused_addr_hi = ^address[31:ADDR_BITS+2];

    assign index      = address[ADDR_BITS+1:2];
    assign lane       = address[1:0];
    assign misaligned = is_misaligned(size, lane);
    assign rd_word    = mem[index];

    dm_load_align u_load_align (
        .word       (rd_word),
        .lane       (lane),
        .size       (size),
        .sign_ext   (sign_ext),
        .misaligned (misaligned),
        .data       (data)
    );

    // Replicate the right-aligned store data across lanes and build the
    // mask of lanes this store actually touches.
    always_comb begin
        wr_word = write_data;
        wr_mask = '1;
        case (size)
            SZ_BYTE: begin
                wr_word = {4{write_data[7:0]}};
                case (lane)
                    2'd0: wr_mask = 32'h0000_00FF;
                    2'd1: wr_mask = 32'h0000_FF00;
                    2'd2: wr_mask = 32'h00FF_0000;
                    2'd3: wr_mask = 32'hFF00_0000;
                    default: wr_mask = 32'h0000_00FF;
                endcase
            end
            SZ_HALF: begin
                wr_word = {2{write_data[15:0]}};
                wr_mask = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            end
            default: begin
                wr_word = write_data;
                wr_mask = '1;
            end
        endcase
    end

    // Reset reloads the whole array with word indices and wins over a store;
    // otherwise an aligned store merges into the selected lanes only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= WORD_W'(i);
            end
        end else if (mem_write && !misaligned) begin
            mem[index] <= (rd_word & ~wr_mask) | (wr_word & wr_mask);
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset contents, word/byte/halfword stores
// and loads, misalignment, address wrap and reset priority.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] data;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    data_memory #(.DEPTH(64), .ADDR_BITS(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .address    (address),
        .write_data (write_data),
        .mem_write  (mem_write),
        .size       (size),
        .sign_ext   (sign_ext),
        .data       (data),
        .misaligned (misaligned)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    // Set up a read and let the combinational path settle.
    task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic sx);
        address   = a;
        size      = sz;
        sign_ext  = sx;
        mem_write = 1'b0;
        #1;
    endtask

    logic [31:0] word_exp [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4};

    initial begin
        rst_n = 1'b0; address = '0; write_data = '0; mem_write = 1'b0;
        size = 2'b10; sign_ext = 1'b0;

        // reset then word reads
        edge_step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd(32'(i * 4), 2'b10, 1'b0);
            check($sformatf("rst_word_%0d", i * 4), data, word_exp[i]);
            check($sformatf("rst_mis_%0d", i * 4), {31'b0, misaligned}, 32'd0);
            edge_step();
        end

        // word store, read-during-write shows old contents
        rd(32'd8, 2'b10, 1'b0);
        write_data = 32'hDEADBEEF; mem_write = 1'b1; #1;
        check("sw_pre", data, 32'h0000_0002);
        edge_step();
        mem_write = 1'b0; #1;
        check("sw_post", data, 32'hDEADBEEF);
        rd(32'd4, 2'b10, 1'b0);
        check("sw_neighbour", data, 32'h0000_0001);

        // byte store then loads
        rd(32'd13, 2'b00, 1'b0);
        write_data = 32'hAAAA_AA80; mem_write = 1'b1;
        edge_step();
        rd(32'd13, 2'b00, 1'b0);
        check("lbu", data, 32'h0000_0080);
        rd(32'd13, 2'b00, 1'b1);
        check("lb", data, 32'hFFFF_FF80);
        rd(32'd12, 2'b10, 1'b0);
        check("sb_word", data, 32'h0000_8003);

        // halfword store then loads
        rd(32'd18, 2'b01, 1'b0);
        write_data = 32'h5555_F00D; mem_write = 1'b1;
        edge_step();
        rd(32'd18, 2'b01, 1'b0);
        check("lhu", data, 32'h0000_F00D);
        rd(32'd18, 2'b01, 1'b1);
        check("lh", data, 32'hFFFF_F00D);
        rd(32'd16, 2'b10, 1'b0);
        check("sh_word", data, 32'hF00D_0004);
        rd(32'd16, 2'b01, 1'b1);
        check("lh_low", data, 32'h0000_0004);

        // misaligned word store is flagged, reads zero and is dropped
        rd(32'd6, 2'b10, 1'b0);
        write_data = 32'h1234_5678; mem_write = 1'b1; #1;
        check("mis_flag", {31'b0, misaligned}, 32'd1);
        check("mis_data", data, 32'd0);
        edge_step();
        rd(32'd4, 2'b10, 1'b0);
        check("mis_dropped", data, 32'h0000_0001);

        // misaligned halfword store dropped, alignment flags per size
        rd(32'd17, 2'b01, 1'b0);
        write_data = 32'h0000_BEEF; mem_write = 1'b1;
        edge_step();
        rd(32'd16, 2'b10, 1'b0);
        check("mis_half_dropped", data, 32'hF00D_0004);
        rd(32'd3, 2'b00, 1'b0);
        check("byte_lane3_ok", {31'b0, misaligned}, 32'd0);
        rd(32'd2, 2'b01, 1'b0);
        check("half_upper_ok", {31'b0, misaligned}, 32'd0);
        rd(32'd4, 2'b11, 1'b0);
        check("size11_word", data, 32'h0000_0001);

        // address wrap
        rd(32'd260, 2'b10, 1'b0);
        check("wrap_260", data, 32'h0000_0001);

        // reset has priority over a simultaneous store
        rst_n = 1'b0; address = 32'd8; size = 2'b10;
        write_data = 32'hCAFE_F00D; mem_write = 1'b1;
        edge_step();
        rst_n = 1'b1; mem_write = 1'b0;
        rd(32'd8, 2'b10, 1'b0);
        check("rst_prio", data, 32'h0000_0002);
        rd(32'd16, 2'b10, 1'b0);
        check("rst_reinit_16", data, 32'h0000_0004);
        rd(32'd12, 2'b10, 1'b0);
        check("rst_reinit_12", data, 32'h0000_0003);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
